level_counter_multi: RTL and testbench
======================================

Name: level_counter_multi

Overview:
Parametrised, multi-channel successor to the single-channel level counter. Replaces the toggled derived slow clock with a single-cycle clock-enable tick from a programmable prescaler. Every flop runs on CLK100MHZ.
Each channel measures how long its level input stays high, in ticks. On the falling edge it captures the result, with saturate/wrap overflow handling and a sticky overflow flag. Sits between button/sensor inputs and the display/readout logic.

Parameters:
N_CH, 4, number of independent channels (1..16)
COUNT_W, 8, counter width per channel in bits (2..32)
TICK_DIV, 50000000, CLK100MHZ cycles per tick (>=1; 50000000 = 2 Hz tick)
SYNC_STAGES, 2, synchroniser depth on each lv_in bit (>=2)

Ports:
CLK100MHZ  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
lv_in  in  N_CH  asynchronous level inputs, one per channel
clr  in  N_CH  synchronous per-channel clear, active-high
mode_sat  in  1  1 = saturate at max, 0 = wrap to 0; shared by all channels, sampled every cycle
tick_out  out  1  one-cycle prescaler tick, for debug or chaining
hold_count  out  N_CH*COUNT_W  live count; channel i occupies bits [i*COUNT_W +: COUNT_W]
last_count  out  N_CH*COUNT_W  count captured at the last falling edge of each channel
done  out  N_CH  one-cycle pulse when last_count[i] updates
ovf  out  N_CH  sticky overflow flag per channel

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0, including tick_out, hold_count, last_count, done and ovf.
  - Prescaler counter 0; synchroniser and edge-detect flops 0.
  - Deassertion takes effect at the next CLK100MHZ edge.
- Prescaler:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick_out=1 for exactly the one cycle where the counter equals TICK_DIV-1.
  - TICK_DIV=1 gives tick_out=1 every cycle.
  - First tick after reset release falls on cycle TICK_DIV (1-based).
  - Free-running; not affected by clr.
- Input path per channel:
  - SYNC_STAGES-flop synchroniser produces lv_s; one extra flop produces lv_d.
  - rise = lv_s & ~lv_d; fall = ~lv_s & lv_d.
  - Latency from lv_in to lv_s is SYNC_STAGES cycles.
- Per-channel priority, evaluated each cycle, highest first:
  1. clr[i]: count<=0, last_count<=0, ovf<=0, done<=0. A simultaneous fall is discarded and produces no done.
  2. fall: last_count<=count, count<=0, done<=1 for one cycle. A coincident tick is not counted.
  3. rise: count<=0; a coincident tick is not counted.
  4. lv_s & tick_out & count<max: count<=count+1.
  5. lv_s & tick_out & count==max (all ones):
     - mode_sat=1: count holds at max.
     - mode_sat=0: count<=0.
     - Either mode: ovf<=1.
  6. Otherwise count holds; done<=0.
- ovf behaviour:
  - Sticky until clr[i] or reset.
  - Not cleared by fall or rise.
  - last_count captures the saturated or wrapped value as-is.
- Independence: channels share only the tick and mode_sat. No channel's behaviour depends on another channel.
- Arithmetic: unsigned, COUNT_W bits. Never widen or truncate across channels.
- Glitches: a high pulse shorter than one cycle may be missed. A high pulse of exactly one synchronised cycle produces rise followed by fall, so done fires with last_count=0.
- Mid-operation reset: aborts all measurements; no done is emitted.

Test Plan:
(Defaults N_CH=2, COUNT_W=4, TICK_DIV=4, SYNC_STAGES=2 unless stated.)
1. Reset, then no stimulus for 20 cycles -> tick_out pulses at cycles 4, 8, 12, 16, 20; all other outputs stay 0.
2. Basic measurement:
   - Stimulus: lv_in[0] high for 5 ticks, then low.
   - Required: hold_count[0] steps 1..5; one done[0] pulse with last_count[0]=5; hold_count[0]=0 afterwards; channel 1 unchanged.
3. Saturate mode:
   - Stimulus: mode_sat=1, lv_in[1] high for 20 ticks.
   - Required: hold_count[1] sticks at 15; ovf[1]=1 from the 16th tick onward; on the fall, last_count[1]=15; ovf[1] stays 1.
4. Wrap mode:
   - Stimulus: mode_sat=0, lv_in[0] high for 18 ticks.
   - Required: count goes 15 -> 0 on the 16th tick, ends at 2; last_count[0]=2; ovf[0]=1.
5. Clear vs. fall collision:
   - Stimulus: assert clr[0] in the same cycle the synchronised fall occurs.
   - Required: done[0] stays 0; last_count[0]=0; hold_count[0]=0; ovf[0]=0.
6. Mid-operation reset:
   - Stimulus: drive reset=0 for 3 cycles while lv_in[0] is high with count=7.
   - Required: all outputs 0 immediately (asynchronous); after release the count restarts from 0 on the next rise; the first tick arrives TICK_DIV cycles after release.

Source files
------------

// File: rtl/level_counter_multi_if.sv
// Purpose: bundles the level inputs, controls and measurement results of level_counter_multi.
// Latency: none, wires only.
// Backpressure: none; every signal is sampled or driven every cycle.
interface level_counter_multi_if #(
    parameter int N_CH    = 4,
    parameter int COUNT_W = 8
);
    logic [N_CH-1:0]         lv_in;
    logic [N_CH-1:0]         clr;
    logic                    mode_sat;
    logic                    tick_out;
    logic [N_CH*COUNT_W-1:0] hold_count;
    logic [N_CH*COUNT_W-1:0] last_count;
    logic [N_CH-1:0]         done;
    logic [N_CH-1:0]         ovf;

    // Stimulus side: drives levels and controls, observes results.
    modport master (
        output lv_in, clr, mode_sat,
        input  tick_out, hold_count, last_count, done, ovf
    );

    // Counter side.
    modport slave (
        input  lv_in, clr, mode_sat,
        output tick_out, hold_count, last_count, done, ovf
    );
endinterface

// File: rtl/level_counter_multi.sv
// Purpose: per-channel high-time measurement in prescaler ticks, with saturate/wrap and sticky overflow.
// Latency: lv_in reaches the counter after SYNC_STAGES cycles; done pulses 1 cycle after the synchronised fall.
// Backpressure: none; inputs are sampled every cycle and results are always valid.
module level_counter_multi #(
    parameter int N_CH        = 4,
    parameter int COUNT_W     = 8,
    parameter int TICK_DIV    = 50000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK100MHZ,
    input  logic                  reset,
    level_counter_multi_if.slave  bus
);

    localparam int                 PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]      PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX  = '1;

    logic [PW-1:0]           pre_q;
    logic                    tick_q;
    logic [N_CH-1:0]         sync_q [SYNC_STAGES];
    logic [N_CH-1:0]         lv_d_q;
    logic [N_CH-1:0]         lv_s;
    logic [N_CH-1:0]         rise;
    logic [N_CH-1:0]         fall;
    logic [N_CH*COUNT_W-1:0] cnt_q;
    logic [N_CH*COUNT_W-1:0] last_q;
    logic [N_CH-1:0]         done_q;
    logic [N_CH-1:0]         ovf_q;

    // Free-running prescaler; the tick is registered so it is low in reset even when TICK_DIV is 1.
    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= (pre_q == PRE_LAST);
            pre_q  <= (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
        end
    end

    // Synchroniser chain plus one delay flop for edge detection.
    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            lv_d_q <= '0;
        end else begin
            sync_q[0] <= bus.lv_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            lv_d_q <= lv_s;
        end
    end

    assign lv_s = sync_q[SYNC_STAGES-1];
    assign rise = lv_s & ~lv_d_q;
    assign fall = ~lv_s & lv_d_q;

    // Per-channel measurement: clear beats fall beats rise beats tick counting.
    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            last_q <= '0;
            done_q <= '0;
            ovf_q  <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                done_q[i] <= 1'b0;
                if (bus.clr[i]) begin
                    cnt_q[i*COUNT_W +: COUNT_W]  <= '0;
                    last_q[i*COUNT_W +: COUNT_W] <= '0;
                    ovf_q[i]                     <= 1'b0;
                end else if (fall[i]) begin
                    last_q[i*COUNT_W +: COUNT_W] <= cnt_q[i*COUNT_W +: COUNT_W];
                    cnt_q[i*COUNT_W +: COUNT_W]  <= '0;
                    done_q[i]                    <= 1'b1;
                end else if (rise[i]) begin
                    cnt_q[i*COUNT_W +: COUNT_W] <= '0;
                end else if (lv_s[i] && tick_q) begin
                    if (cnt_q[i*COUNT_W +: COUNT_W] != CNT_MAX) begin
                        cnt_q[i*COUNT_W +: COUNT_W] <= cnt_q[i*COUNT_W +: COUNT_W] + COUNT_W'(1);
                    end else begin
                        // At max: saturate holds the value, wrap restarts from zero.
                        if (!bus.mode_sat) begin
                            cnt_q[i*COUNT_W +: COUNT_W] <= '0;
                        end
                        ovf_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.tick_out   = tick_q;
    assign bus.hold_count = cnt_q;
    assign bus.last_count = last_q;
    assign bus.done       = done_q;
    assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_level_counter_multi.sv
// Bench for level_counter_multi: table of measurement vectors, done-pulse scoreboard,
// plus hand-written sequences for idle ticking, clear/fall collision, glitch and mid-run reset.
module tb_level_counter_multi;

    localparam int N_CH        = 2;
    localparam int COUNT_W     = 4;
    localparam int TICK_DIV    = 4;
    localparam int SYNC_STAGES = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    level_counter_multi_if #(.N_CH(N_CH), .COUNT_W(COUNT_W)) bus ();

    level_counter_multi #(
        .N_CH       (N_CH),
        .COUNT_W    (COUNT_W),
        .TICK_DIV   (TICK_DIV),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .CLK100MHZ(clk),
        .reset    (rst_n),
        .bus      (bus)
    );

    typedef struct {
        int         ch;
        logic [3:0] last;
        logic       ovf;
    } sb_t;

    typedef struct {
        int         ch;
        logic       sat;
        int         ticks;
        logic [3:0] exp_last;
        logic       exp_ovf;
    } vec_t;

    int         checks   = 0;
    int         failures = 0;
    int         cyc;
    sb_t        sb_q[$];
    sb_t        sb_e;
    logic [3:0] exp_last [N_CH];
    logic       exp_ovf  [N_CH];

    // Edges seen since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] hc(input int c);
        return bus.hold_count[c*COUNT_W +: COUNT_W];
    endfunction

    function automatic logic [3:0] lc(input int c);
        return bus.last_count[c*COUNT_W +: COUNT_W];
    endfunction

    // Scoreboard: every done pulse must match the oldest pushed expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                if (bus.done[c]) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_done", 64'(c + 16), 64'(0));
                    end else begin
                        sb_e = sb_q.pop_front();
                        check("done_channel", 64'(c), 64'(sb_e.ch));
                        check("done_last_count", 64'(lc(c)), 64'(sb_e.last));
                        check("done_ovf", 64'(bus.ovf[c]), 64'(sb_e.ovf));
                    end
                end
            end
        end
    end

    task automatic push_exp(input int c, input logic [3:0] last, input logic o);
        sb_t e;
        e.ch   = c;
        e.last = last;
        e.ovf  = o;
        sb_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Return just after an edge on which the tick register went high.
    task automatic wait_phase0();
        do step(1); while (cyc % TICK_DIV != 0);
    endtask

    task automatic clear_ch(input int c);
        bus.clr[c] = 1'b1;
        step(1);
        bus.clr[c] = 1'b0;
        exp_last[c] = '0;
        exp_ovf[c]  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int   m;
        logic o;
        int   oc;
        oc = 1 - v.ch;
        clear_ch(v.ch);
        bus.mode_sat = v.sat;
        wait_phase0();
        bus.lv_in[v.ch] = 1'b1;
        m = 0;
        o = 1'b0;
        for (int k = 1; k <= v.ticks; k++) begin
            step(TICK_DIV);
            check("live_count", 64'(hc(v.ch)), 64'(m));
            check("live_ovf", 64'(bus.ovf[v.ch]), 64'(o));
            if (m == 15) begin
                o = 1'b1;
                if (!v.sat) m = 0;
            end else begin
                m = m + 1;
            end
        end
        bus.lv_in[v.ch] = 1'b0;
        push_exp(v.ch, v.exp_last, v.exp_ovf);
        step(6);
        check("count_after_fall", 64'(hc(v.ch)), 64'(0));
        check("last_after_fall", 64'(lc(v.ch)), 64'(v.exp_last));
        check("ovf_after_fall", 64'(bus.ovf[v.ch]), 64'(v.exp_ovf));
        check("other_count", 64'(hc(oc)), 64'(0));
        check("other_last", 64'(lc(oc)), 64'(exp_last[oc]));
        check("other_ovf", 64'(bus.ovf[oc]), 64'(exp_ovf[oc]));
        exp_last[v.ch] = v.exp_last;
        exp_ovf[v.ch]  = v.exp_ovf;
    endtask

    initial begin
        vec_t vecs [7];
        vecs[0] = '{ch: 0, sat: 1'b1, ticks: 5,  exp_last: 4'd5,  exp_ovf: 1'b0};
        vecs[1] = '{ch: 1, sat: 1'b1, ticks: 20, exp_last: 4'd15, exp_ovf: 1'b1};
        vecs[2] = '{ch: 0, sat: 1'b0, ticks: 18, exp_last: 4'd2,  exp_ovf: 1'b1};
        vecs[3] = '{ch: 1, sat: 1'b0, ticks: 3,  exp_last: 4'd3,  exp_ovf: 1'b0};
        vecs[4] = '{ch: 0, sat: 1'b0, ticks: 15, exp_last: 4'd15, exp_ovf: 1'b0};
        vecs[5] = '{ch: 1, sat: 1'b0, ticks: 16, exp_last: 4'd0,  exp_ovf: 1'b1};
        vecs[6] = '{ch: 0, sat: 1'b1, ticks: 16, exp_last: 4'd15, exp_ovf: 1'b1};

        for (int c = 0; c < N_CH; c++) begin
            exp_last[c] = '0;
            exp_ovf[c]  = 1'b0;
        end
        rst_n        = 1'b0;
        bus.lv_in    = '0;
        bus.clr      = '0;
        bus.mode_sat = 1'b0;
        step(3);
        check("reset_outputs", {bus.tick_out, bus.hold_count, bus.last_count, bus.done, bus.ovf}, 64'(0));
        rst_n = 1'b1;

        // Idle: tick every TICK_DIV edges, nothing else moves.
        for (int k = 1; k <= 20; k++) begin
            step(1);
            check("idle_tick", 64'(bus.tick_out), 64'((k % TICK_DIV) == 0));
            check("idle_outputs", {bus.hold_count, bus.last_count, bus.done, bus.ovf}, 64'(0));
        end

        for (int v = 0; v < 7; v++) begin
            run_vec(vecs[v]);
        end

        // Clear lands on the same cycle as the synchronised fall: no done, everything zeroed.
        bus.mode_sat = 1'b0;
        wait_phase0();
        bus.lv_in[0] = 1'b1;
        step(TICK_DIV * 17);
        bus.lv_in[0] = 1'b0;
        step(2);
        check("collide_pre_ovf", 64'(bus.ovf[0]), 64'(1));
        check("collide_pre_count", 64'(hc(0)), 64'(1));
        bus.clr[0] = 1'b1;
        step(1);
        bus.clr[0] = 1'b0;
        step(6);
        check("collide_count", 64'(hc(0)), 64'(0));
        check("collide_last", 64'(lc(0)), 64'(0));
        check("collide_ovf", 64'(bus.ovf[0]), 64'(0));
        exp_last[0] = '0;
        exp_ovf[0]  = 1'b0;

        // One-cycle glitch: rise then fall, done with a zero measurement.
        clear_ch(1);
        bus.lv_in[1] = 1'b1;
        step(1);
        bus.lv_in[1] = 1'b0;
        push_exp(1, 4'd0, 1'b0);
        step(6);
        check("glitch_last", 64'(lc(1)), 64'(0));
        check("glitch_count", 64'(hc(1)), 64'(0));
        exp_last[1] = '0;

        // Mid-measurement reset on a count of 7, with a stale last_count on channel 1.
        run_vec('{ch: 1, sat: 1'b1, ticks: 4, exp_last: 4'd4, exp_ovf: 1'b0});
        wait_phase0();
        bus.lv_in[0] = 1'b1;
        step(TICK_DIV * 8);
        check("midreset_pre_count", 64'(hc(0)), 64'(7));
        rst_n = 1'b0;
        #1;
        check("midreset_async", {bus.tick_out, bus.hold_count, bus.last_count, bus.done, bus.ovf}, 64'(0));
        step(3);
        check("midreset_held", {bus.tick_out, bus.hold_count, bus.last_count, bus.done, bus.ovf}, 64'(0));
        rst_n = 1'b1;
        for (int c = 0; c < N_CH; c++) begin
            exp_last[c] = '0;
            exp_ovf[c]  = 1'b0;
        end
        for (int k = 1; k <= TICK_DIV; k++) begin
            step(1);
            check("post_reset_tick", 64'(bus.tick_out), 64'(k == TICK_DIV));
        end
        step(TICK_DIV);
        check("post_reset_count", 64'(hc(0)), 64'(1));
        bus.lv_in[0] = 1'b0;
        push_exp(0, 4'd2, 1'b0);
        step(6);
        check("post_reset_last", 64'(lc(0)), 64'(2));
        check("post_reset_ovf", 64'(bus.ovf), 64'(0));

        step(4);
        check("scoreboard_drained", 64'(sb_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
